// File: rtl/fifo_drain.sv
// Drains a source FIFO into a valid/ready stream through a 2-entry skid buffer,
// priming on a fill threshold. Optional underrun counter: FIFO_DRAIN_UNDERRUN_CNT_EN.
module fifo_drain #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned PRIME_EN_DEF = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic              fifo_threshold,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              fifo_rd,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              running,
  output logic [7:0]        underrun_cnt
);

  localparam int unsigned OCC_W = 2;
  localparam int unsigned LVL_W = 3;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRIME,
    S_RUN,
    S_STOP
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [OCC_W-1:0]   occ;
  logic               inflight;
  logic [DATA_W-1:0]  buf0;
  logic [DATA_W-1:0]  buf1;
  logic               pop;
  logic               start_ok;
  logic               starve;
  logic [LVL_W-1:0]   level;

  assign pop      = m_valid && m_ready;
  assign m_valid  = (occ != OCC_W'(0));
  assign m_data   = buf0;
  assign running  = (state == S_RUN);
  assign start_ok = (PRIME_EN_DEF != 0) ? fifo_threshold : !fifo_empty;
  assign starve   = (occ == OCC_W'(0)) && !inflight && fifo_empty && m_ready;

  // Occupancy the buffer will have once this cycle's pop and landing read settle.
  assign level = LVL_W'(occ) + LVL_W'(inflight) - LVL_W'(pop);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and read strobe
  always_comb begin
    state_nxt = state;
    fifo_rd   = 1'b0;
    case (state)
      S_IDLE: begin
        if (enable) state_nxt = S_PRIME;
      end
      S_PRIME: begin
        if (!enable)       state_nxt = S_IDLE;
        else if (start_ok) state_nxt = S_RUN;
      end
      S_RUN: begin
        fifo_rd = !fifo_empty && (level < LVL_W'(2));
        if (!enable)     state_nxt = S_STOP;
        else if (starve) state_nxt = S_PRIME;
      end
      S_STOP: begin
        if ((occ == OCC_W'(0)) && !inflight) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Skid buffer: buf0 is always the oldest entry; read data lands one cycle after fifo_rd.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= 1'b0;
      occ      <= '0;
      buf0     <= '0;
      buf1     <= '0;
    end else begin
      inflight <= fifo_rd;
      occ      <= occ + OCC_W'(inflight) - OCC_W'(pop);
      case ({inflight, pop})
        2'b01: buf0 <= buf1;
        2'b10: begin
          if (occ == OCC_W'(0)) buf0 <= fifo_dout;
          else                  buf1 <= fifo_dout;
        end
        2'b11: begin
          if (occ == OCC_W'(1)) begin
            buf0 <= fifo_dout;
          end else begin
            buf0 <= buf1;
            buf1 <= fifo_dout;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FIFO_DRAIN_UNDERRUN_CNT_EN
  logic             underrun_evt;
  logic [CNT_W-1:0] ucnt;

  assign underrun_evt = (state == S_RUN) && enable && starve;

  // Saturating starvation counter, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ucnt <= '0;
    end else if (underrun_evt && (ucnt != {CNT_W{1'b1}})) begin
      ucnt <= ucnt + CNT_W'(1);
    end
  end

  assign underrun_cnt = ucnt;
`else
  assign underrun_cnt = CNT_W'(0);
`endif

endmodule

// File: tb/tb_fifo_drain.sv
// Scoreboard bench for fifo_drain: a behavioural 16-deep FIFO feeds the DUT,
// a negedge monitor checks every downstream transfer against pushed samples.
module tb_fifo_drain;

`ifdef FIFO_DRAIN_UNDERRUN_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       m_ready = 1'b0;
  logic       fifo_empty;
  logic       fifo_threshold;
  logic [7:0] fifo_dout = 8'h00;
  logic       fifo_rd;
  logic [7:0] m_data;
  logic       m_valid;
  logic       running;
  logic [7:0] underrun_cnt;

  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic [7:0] fq[$];
  int         fcnt = 0;

  logic [7:0] exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         rd_total = 0;
  int         xfer_total = 0;
  int         outstanding = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  fifo_drain #(.DATA_W(8), .PRIME_EN_DEF(1)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .fifo_empty     (fifo_empty),
    .fifo_threshold (fifo_threshold),
    .fifo_dout      (fifo_dout),
    .fifo_rd        (fifo_rd),
    .m_data         (m_data),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .running        (running),
    .underrun_cnt   (underrun_cnt)
  );

  always #5 clk = ~clk;

  assign fifo_empty     = (fcnt == 0);
  assign fifo_threshold = (fcnt >= 8);

  // Source FIFO model: registered read data, flushed by system reset
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fq.delete();
      fcnt <= 0;
    end else begin
      if (fifo_rd && fq.size() > 0) fifo_dout <= fq.pop_front();
      if (wr_en) fq.push_back(wr_data);
      fcnt <= fq.size();
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] exp_u(input int n);
    return CNT_EN ? 32'(n) : 32'd0;
  endfunction

  // Monitor: transfer/read decisions seen here take effect at the following posedge
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall  = 1'b0;
      outstanding = 0;
    end else begin
      if (prev_stall) begin
        chk("stall_hold_valid", 32'(m_valid), 32'd1);
        chk("stall_hold_data", 32'(m_data), 32'(prev_data));
      end
      chk("outstanding_le2", 32'(outstanding <= 2), 32'd1);
      if (fifo_rd) chk("no_underflow", 32'(fifo_empty), 32'd0);
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_sample: got %0h required none", m_data);
        end else begin
          chk("sample", 32'(m_data), 32'(exp_q.pop_front()));
        end
        xfer_total++;
      end
      outstanding += int'(fifo_rd) - int'(m_valid && m_ready);
      if (fifo_rd) rd_total++;
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    exp_q.push_back(d);
    step();
    wr_en = 1'b0;
  endtask

  task automatic wait_drained(input string name);
    int n = 0;
    while (!(exp_q.size() == 0 && !running && !m_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(n < 200), 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_fifo_rd"}, 32'(fifo_rd), 32'd0);
    chk({tag, "_m_valid"}, 32'(m_valid), 32'd0);
    chk({tag, "_m_data"}, 32'(m_data), 32'd0);
    chk({tag, "_running"}, 32'(running), 32'd0);
    chk({tag, "_underrun"}, 32'(underrun_cnt), 32'd0);
  endtask

  initial begin
    int n;
    int cnt;
    int rd0;
    int x0;
    int idx;
    logic [3:0] pat;

    // Reset state
    step();
    chk_reset_vals("reset");
    rst_n = 1'b1;
    step();
    step();

    // Prime: no reads below threshold, first sample 2 cycles after RUN entry
    enable  = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 7; i++) push(8'hA0 + 8'(i));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("prime_no_rd", 32'(fifo_rd), 32'd0);
      chk("prime_not_running", 32'(running), 32'd0);
    end
    push(8'hA7);
    n = 0;
    while (!running && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("run_entry", 32'(running), 32'd1);
    n = 0;
    while (!m_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("first_valid_latency", 32'(n), 32'd2);
    wait_drained("drain_prime");
    chk("underrun_after_prime", 32'(underrun_cnt), exp_u(1));

    // Throughput: 16 queued samples drain back-to-back
    enable = 1'b0;
    step();
    step();
    for (int i = 1; i <= 16; i++) push(8'(i));
    chk("idle_no_rd", 32'(fifo_rd), 32'd0);
    rd0    = rd_total;
    enable = 1'b1;
    n = 0;
    while (!m_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    cnt = 0;
    while (m_valid && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    chk("consecutive_valid", 32'(cnt), 32'd16);
    wait_drained("drain_throughput");
    chk("rd_cycles", 32'(rd_total - rd0), 32'd16);
    chk("underrun_after_tput", 32'(underrun_cnt), exp_u(2));

    // Backpressure with m_ready pattern 1,0,0,1
    pat = 4'b1001;
    idx = 0;
    for (int i = 0; i < 12; i++) begin
      m_ready = pat[idx % 4];
      idx++;
      push(8'h30 + 8'(i));
    end
    for (int i = 0; i < 40; i++) begin
      m_ready = pat[idx % 4];
      idx++;
      step();
    end
    m_ready = 1'b1;
    wait_drained("drain_backpressure");
    chk("underrun_after_bp", 32'(underrun_cnt), exp_u(3));

    // Stop with a full skid buffer
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(8'h40 + 8'(i));
    repeat (4) step();
    @(negedge clk);
    chk("full_hold_rd", 32'(fifo_rd), 32'd0);
    chk("full_running", 32'(running), 32'd1);
    step();
    enable = 1'b0;
    step();
    @(negedge clk);
    chk("stop_no_rd", 32'(fifo_rd), 32'd0);
    chk("stop_not_running", 32'(running), 32'd0);
    step();
    x0      = xfer_total;
    m_ready = 1'b1;
    repeat (6) step();
    chk("stop_delivered", 32'(xfer_total - x0), 32'd2);
    chk("stop_idle_valid", 32'(m_valid), 32'd0);
    chk("stop_idle_rd", 32'(fifo_rd), 32'd0);
    chk("underrun_after_stop", 32'(underrun_cnt), exp_u(3));

    // Reset mid-stream while a read is in flight
    enable = 1'b1;
    for (int i = 0; i < 4; i++) push(8'h48 + 8'(i));
    n = 0;
    while (!fifo_rd && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("reset_setup_rd", 32'(fifo_rd), 32'd1);
    step();
    rst_n  = 1'b0;
    enable = 1'b0;
    exp_q.delete();
    #1;
    chk_reset_vals("midreset");
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_reset_no_valid", 32'(m_valid), 32'd0);
    end

    // Resume after reset
    step();
    enable  = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) push(8'h50 + 8'(i));
    wait_drained("drain_final");
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    chk("underrun_final", 32'(underrun_cnt), exp_u(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
